// File: rtl/tbird_mode_ctrl.sv
// Front-end for the Thunderbird taillight sequencer: synchronizes and debounces
// the four driver controls, encodes the lamp mode and paces the sequence steps.
module tbird_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       hazard_in,
  input  logic       brake_in,
  output logic [2:0] switch,
  output logic       step_tick,
  output logic       mode_change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  // Bit order for all per-input vectors: 0 left, 1 right, 2 hazard, 3 brake.
  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    stable_q, stable_d;
  logic [CW-1:0] count_q [4];
  logic [CW-1:0] count_d [4];

  logic [2:0]    switch_q, mode_d;
  logic          mode_change_q, mode_diff;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick_q, tick_d;

  assign raw = {brake_in, hazard_in, right_in, left_in};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      count_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (count_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          count_d[i] = count_q[i] + CW'(1);
        end
      end
    end
  end

  // Hazard, or both levers at once, runs the full hazard pattern.
  always_comb begin
    mode_d = {stable_q[3], stable_q[0], stable_q[1]};
    if (stable_q[2] || (stable_q[0] && stable_q[1])) begin
      mode_d[1:0] = 2'b11;
    end
  end

  assign mode_diff = (mode_d != switch_q);

  always_comb begin
    tcnt_d = tcnt_q + TW'(1);
    tick_d = 1'b0;
    if (mode_diff) begin
      tcnt_d = '0;
    end else if (tcnt_q == TICK_LAST) begin
      tcnt_d = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      for (int i = 0; i < 4; i++) count_q[i] <= '0;
      switch_q      <= 3'b000;
      mode_change_q <= 1'b0;
      tcnt_q        <= '0;
      tick_q        <= 1'b0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      for (int i = 0; i < 4; i++) count_q[i] <= count_d[i];
      switch_q      <= mode_d;
      mode_change_q <= mode_diff;
      tcnt_q        <= tcnt_d;
      tick_q        <= tick_d;
    end
  end

  assign switch      = switch_q;
  assign mode_change = mode_change_q;
  assign step_tick   = tick_q;

endmodule

// File: tb/tb_tbird_mode_ctrl.sv
// Bench for tbird_mode_ctrl: directed scenarios plus random bouncy inputs,
// every cycle compared against a sample-history reference model.
module tb_tbird_mode_ctrl;

  localparam int DB = 4;
  localparam int TD = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       left_in, right_in, hazard_in, brake_in;
  logic [2:0] switch;
  logic       step_tick, mode_change;

  int n_checks = 0;
  int n_fail   = 0;
  int mc_seen  = 0;

  tbird_mode_ctrl #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clock       (clock),
    .reset       (reset),
    .left_in     (left_in),
    .right_in    (right_in),
    .hazard_in   (hazard_in),
    .brake_in    (brake_in),
    .switch      (switch),
    .step_tick   (step_tick),
    .mode_change (mode_change)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw samples travel through a two-deep delay line; a control's settled level
  // flips once the delayed sample has disagreed with it for DB edges in a row.
  // Ticks fall on every TD-th edge counted from the last mode change or reset.
  int unsigned edge_n = 0;
  int unsigned anchor = 0;
  logic [3:0]  dly_q[$];
  logic [3:0]  m_settled;
  int          m_disagree[4];
  logic [2:0]  m_switch;
  logic        m_mc, m_tick;

  function automatic logic [2:0] lamp_mode(input logic [3:0] s);
    bit brake, lft, rgt;
    brake = s[3];
    lft   = s[0];
    rgt   = s[1];
    if (s[2] || (lft && rgt)) begin
      lft = 1'b1;
      rgt = 1'b1;
    end
    return {brake, lft, rgt};
  endfunction

  task automatic model_reset();
    dly_q     = '{4'b0000, 4'b0000};
    m_settled = '0;
    for (int i = 0; i < 4; i++) m_disagree[i] = 0;
    m_switch  = 3'b000;
    m_mc      = 1'b0;
    m_tick    = 1'b0;
    anchor    = edge_n;
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] raw);
    logic [2:0] nm;
    logic [3:0] delayed;
    edge_n++;
    if (rst) begin
      model_reset();
      return;
    end
    nm   = lamp_mode(m_settled);
    m_mc = (nm != m_switch);
    if (m_mc) begin
      anchor = edge_n;
      m_tick = 1'b0;
    end else begin
      m_tick = ((edge_n - anchor) % TD) == 0;
    end
    delayed = dly_q[1];
    for (int i = 0; i < 4; i++) begin
      if (delayed[i] != m_settled[i]) begin
        m_disagree[i]++;
        if (m_disagree[i] == DB) begin
          m_settled[i]  = delayed[i];
          m_disagree[i] = 0;
        end
      end else begin
        m_disagree[i] = 0;
      end
    end
    dly_q.pop_back();
    dly_q.push_front(raw);
    m_switch = nm;
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clock);
    model_edge(reset, {brake_in, hazard_in, right_in, left_in});
    #1;
    check_eq("switch", 32'(switch), 32'(m_switch));
    check_eq("mode_change", 32'(mode_change), 32'(m_mc));
    check_eq("step_tick", 32'(step_tick), 32'(m_tick));
    if (mode_change === 1'b1) mc_seen++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int       hold[4];
  logic [3:0] lvl;

  initial begin
    reset = 1'b1;
    left_in = 1'b0; right_in = 1'b0; hazard_in = 1'b0; brake_in = 1'b0;
    model_reset();

    // Reset then idle.
    steps(3);
    check_eq("rst_switch", 32'(switch), 32'd0);
    check_eq("rst_mc", 32'(mode_change), 32'd0);
    check_eq("rst_tick", 32'(step_tick), 32'd0);
    reset = 1'b0;
    mc_seen = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      check_eq("idle_tick", 32'(step_tick), 32'((i % TD) == 0));
    end
    check_eq("idle_mc_count", 32'(mc_seen), 32'd0);

    // Clean left press: first sampled at the next edge k.
    left_in = 1'b1;
    steps(6);
    check_eq("left_k5_switch", 32'(switch), 32'b000);
    step();
    check_eq("left_k6_switch", 32'(switch), 32'b010);
    check_eq("left_k6_mc", 32'(mode_change), 32'd1);
    steps(4);
    check_eq("left_k10_tick", 32'(step_tick), 32'd0);
    step();
    check_eq("left_k11_tick", 32'(step_tick), 32'd1);

    // Bounce rejection on the right lever.
    left_in = 1'b0;
    steps(10);
    check_eq("left_off", 32'(switch), 32'b000);
    mc_seen = 0;
    right_in = 1'b1; steps(3);
    right_in = 1'b0; steps(1);
    right_in = 1'b1; steps(2);
    right_in = 1'b0; steps(10);
    check_eq("bounce_switch", 32'(switch), 32'b000);
    check_eq("bounce_mc_count", 32'(mc_seen), 32'd0);
    right_in = 1'b1; steps(10);
    check_eq("right_held", 32'(switch), 32'b001);

    // Conflict, then hazard taking over on the same edge.
    left_in = 1'b1; steps(10);
    check_eq("conflict", 32'(switch), 32'b011);
    mc_seen = 0;
    left_in = 1'b0; right_in = 1'b0; hazard_in = 1'b1;
    steps(12);
    check_eq("hazard_switch", 32'(switch), 32'b011);
    check_eq("hazard_mc_count", 32'(mc_seen), 32'd0);

    // Brake overlay on left.
    hazard_in = 1'b0; left_in = 1'b1; steps(12);
    check_eq("left_again", 32'(switch), 32'b010);
    mc_seen = 0;
    brake_in = 1'b1; steps(10);
    check_eq("brake_left", 32'(switch), 32'b110);
    check_eq("brake_on_mc_count", 32'(mc_seen), 32'd1);
    mc_seen = 0;
    brake_in = 1'b0; steps(10);
    check_eq("brake_off", 32'(switch), 32'b010);
    check_eq("brake_off_mc_count", 32'(mc_seen), 32'd1);

    // Reset mid-debounce of brake.
    left_in = 1'b0; steps(10);
    brake_in = 1'b1; steps(2);
    reset = 1'b1; steps(1);
    check_eq("mid_rst_switch", 32'(switch), 32'b000);
    check_eq("mid_rst_mc", 32'(mode_change), 32'd0);
    reset = 1'b0;
    steps(6);
    check_eq("post_rst_k5", 32'(switch), 32'b000);
    step();
    check_eq("post_rst_k6", 32'(switch), 32'b100);
    brake_in = 1'b0; steps(10);

    // Random bouncy controls with occasional simultaneous moves and resets.
    for (int i = 0; i < 4; i++) hold[i] = 0;
    lvl = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if ($urandom_range(0, 39) == 0) begin
        lvl = 4'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) hold[i] = 10;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (hold[i] == 0) begin
            lvl[i]  = 1'($urandom_range(0, 1));
            hold[i] = $urandom_range(1, 14);
          end else begin
            hold[i]--;
          end
        end
      end
      left_in   = lvl[0];
      right_in  = lvl[1];
      hazard_in = lvl[2];
      brake_in  = lvl[3];
      reset     = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
